// File: rtl/btb_update_controller.sv
// btb_update_controller
//
// Shares the single BTB PC/index port between fetch-stage lookups and
// branch-resolution updates. Resolved branches are buffered in a small FIFO
// and written into the BTB when fetch is idle. A write is forced when the
// FIFO is full or when the head entry has waited too long. A flush request
// starts a walk that invalidates every BTB index.
//
// Optional feature: define BTB_NT_INVALIDATE_EN to enqueue not-taken
// updates. Each one invalidates its BTB entry if that entry currently hits.
// When the macro is undefined, not-taken updates are accepted and dropped,
// and btb_hit is ignored.
//
// Handshake: an update transfers on a rising edge where upd_valid and
// upd_ready are both high. upd_ready does not depend on upd_valid.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_req/fetch_pc      lookup request and PC from fetch
//   fetch_stall             lookup not serviced this cycle (fetch retries)
//   upd_valid/upd_ready     update handshake
//   upd_pc/upd_target/upd_taken  resolved branch
//   flush_req/flush_busy    invalidate request / walk in progress
//   btb_hit                 BTB hit for the driven btb_pc
//   btb_pc/btb_bta_in/btb_valid_in  BTB address and write data
//   btb_ld_valid/btb_ld_tag/btb_ld_busy  BTB write strobes
module btb_update_controller #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int INDEX_WIDTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_pc,
  output logic        fetch_stall,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_pc,
  input  logic [15:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush_req,
  output logic        flush_busy,
  input  logic        btb_hit,
  output logic [15:0] btb_pc,
  output logic [15:0] btb_bta_in,
  output logic        btb_valid_in,
  output logic        btb_ld_valid,
  output logic        btb_ld_tag,
  output logic        btb_ld_busy
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] flush_idx_q, flush_idx_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [SC_W-1:0]        starve_q, starve_d;
  // Each FIFO entry is packed as {pc[15:0], target[15:0], taken}.
  logic [32:0]            mem_q [QUEUE_DEPTH];
  logic [32:0]            mem_d [QUEUE_DEPTH];

  logic        fifo_empty, fifo_full, starved;
  logic        do_write, push;
  logic [15:0] head_pc, head_tgt;
  logic        head_tkn;
  logic        unused_inputs;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign starved    = (starve_q >= SC_W'(STARVE_LIMIT));
  assign head_pc    = mem_q[rd_ptr_q][32:17];
  assign head_tgt   = mem_q[rd_ptr_q][16:1];
  assign head_tkn   = mem_q[rd_ptr_q][0];
  assign unused_inputs = ^{btb_hit, head_tkn};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
    end
  end

  // FIFO storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_idx_q == {INDEX_WIDTH{1'b1}}) begin
          state_d     = ST_IDLE;
          flush_idx_d = '0;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    upd_ready    = 1'b0;
    flush_busy   = 1'b0;
    fetch_stall  = 1'b0;
    btb_pc       = fetch_pc;
    btb_bta_in   = '0;
    btb_valid_in = 1'b0;
    btb_ld_valid = 1'b0;
    btb_ld_tag   = 1'b0;
    btb_ld_busy  = 1'b0;
    do_write     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        upd_ready = !fifo_full && !flush_req;
        do_write  = !fifo_empty && (!fetch_req || fifo_full || starved) && !flush_req;
        if (do_write) begin
          fetch_stall = fetch_req;
          btb_pc      = head_pc;
          if (head_tkn) begin
            btb_bta_in   = head_tgt;
            btb_valid_in = 1'b1;
            btb_ld_valid = 1'b1;
            btb_ld_tag   = 1'b1;
            btb_ld_busy  = 1'b1;
          end
`ifdef BTB_NT_INVALIDATE_EN
          else begin
            // A not-taken entry only clears the valid bit, and only if the
            // entry is resident.
            btb_ld_valid = btb_hit;
          end
`endif
        end
      end
      ST_FLUSH: begin
        flush_busy   = 1'b1;
        fetch_stall  = fetch_req;
        btb_pc       = 16'({flush_idx_q, 1'b0});
        btb_ld_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO pointers, occupancy and starvation counter
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
`ifdef BTB_NT_INVALIDATE_EN
    push = upd_valid && upd_ready;
`else
    push = upd_valid && upd_ready && upd_taken;
`endif
    if (state_q != ST_IDLE || flush_req) begin
      // A flush discards every queued update.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      starve_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {upd_pc, upd_target, upd_taken};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_write) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !do_write)      count_d = count_q + 1'b1;
      else if (!push && do_write) count_d = count_q - 1'b1;
      if (do_write || fifo_empty) starve_d = '0;
      else if (!starved)          starve_d = starve_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_btb_update_controller.sv
module tb_btb_update_controller;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef BTB_NT_INVALIDATE_EN
  localparam bit NT_EN = 1'b1;
`else
  localparam bit NT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, upd_valid, upd_taken, flush_req;
  logic [15:0] fetch_pc, upd_pc, upd_target;
  logic        fetch_stall, upd_ready, flush_busy, btb_hit;
  logic [15:0] btb_pc, btb_bta_in;
  logic        btb_valid_in, btb_ld_valid, btb_ld_tag, btb_ld_busy;

  int n_cmp = 0;
  int n_fail = 0;

  btb_update_controller dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .flush_req(flush_req), .flush_busy(flush_busy), .btb_hit(btb_hit),
    .btb_pc(btb_pc), .btb_bta_in(btb_bta_in), .btb_valid_in(btb_valid_in),
    .btb_ld_valid(btb_ld_valid), .btb_ld_tag(btb_ld_tag), .btb_ld_busy(btb_ld_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural BTB memory, written from the DUT strobes
  bit        bv   [16];
  bit [15:0] btag [16];
  bit [15:0] bbta [16];
  logic [15:0] cap_pc, cap_bta;
  logic        cap_vin, cap_lv, cap_lt, cap_lb;

  function automatic bit bhit(input logic [15:0] p);
    return bv[p[4:1]] && (btag[p[4:1]] == p);
  endfunction

  assign btb_hit = bhit(btb_pc);

  always @(negedge clk) begin
    cap_pc = btb_pc; cap_bta = btb_bta_in; cap_vin = btb_valid_in;
    cap_lv = btb_ld_valid; cap_lt = btb_ld_tag; cap_lb = btb_ld_busy;
  end

  always @(posedge clk) begin
    if (cap_lv === 1'b1) bv[cap_pc[4:1]]   = cap_vin;
    if (cap_lt === 1'b1) btag[cap_pc[4:1]] = cap_pc;
    if (cap_lb === 1'b1) bbta[cap_pc[4:1]] = cap_bta;
  end

  // Controller model: queue of {pc, target, taken}, flush walk counter
  logic [32:0] mq[$];
  bit          m_flush;
  int          m_idx;
  int          m_starve;

  function automatic bit m_write();
    if (m_flush) return 1'b0;
    return (mq.size() > 0) && (!fetch_req || mq.size() == DEPTH || m_starve >= LIMIT) && !flush_req;
  endfunction

  // {stall, ready, busy, valid_in, ld_valid, ld_tag, ld_busy, pc, bta}
  function automatic logic [38:0] m_expect();
    logic [32:0] h;
    logic        rdy;
    if (m_flush) return {fetch_req, 1'b0, 1'b1, 1'b0, 3'b100, 16'(m_idx * 2), 16'h0};
    rdy = (mq.size() < DEPTH) && !flush_req;
    if (!m_write()) return {1'b0, rdy, 1'b0, 4'b0000, fetch_pc, 16'h0};
    h = mq[0];
    if (h[0]) return {fetch_req, rdy, 1'b0, 1'b1, 3'b111, h[32:17], h[16:1]};
    return {fetch_req, rdy, 1'b0, 1'b0, bhit(h[32:17]), 2'b00, h[32:17], 16'h0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  pre;
    bit  w;
    if (!rst_n) begin
      mq.delete(); m_flush = 1'b0; m_idx = 0; m_starve = 0;
    end else if (m_flush) begin
      m_idx++;
      if (m_idx == 16) begin m_flush = 1'b0; m_idx = 0; end
    end else if (flush_req) begin
      m_flush = 1'b1; m_idx = 0; mq.delete(); m_starve = 0;
    end else begin
      w   = m_write();
      pre = mq.size();
      if (w) begin
        mq.delete(0);
        m_starve = 0;
      end else if (pre > 0) begin
        m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      end else begin
        m_starve = 0;
      end
      if (upd_valid && pre < DEPTH && (upd_taken || NT_EN))
        mq.push_back({upd_pc, upd_target, upd_taken});
    end
  end

  // Scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n)
      check("cycle_outputs",
            {fetch_stall, upd_ready, flush_busy, btb_valid_in, btb_ld_valid,
             btb_ld_tag, btb_ld_busy, btb_pc, btb_bta_in}, m_expect());
  end

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_upd(input logic v, input logic [15:0] pc, input logic [15:0] tgt,
                           input logic tk);
    upd_valid = v; upd_pc = pc; upd_target = tgt; upd_taken = tk;
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = 16'h1234; flush_req = 1'b0;
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) step();
    sample();
    check("reset_outputs",
          {fetch_stall, upd_ready, flush_busy, btb_ld_valid, btb_ld_tag, btb_ld_busy, btb_pc},
          {1'b0, 1'b1, 1'b0, 3'b000, 16'h1234});

    // Single taken update while fetch is idle
    step();
    rst_n = 1'b1;
    drive_upd(1'b1, 16'h3006, 16'h3100, 1'b1);
    sample();
    check("first_upd_ready", upd_ready, 1'b1);
    step();
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("idle_write",
          {fetch_stall, btb_valid_in, btb_ld_valid, btb_ld_tag, btb_ld_busy, btb_pc, btb_bta_in},
          {1'b0, 1'b1, 3'b111, 16'h3006, 16'h3100});
    step();
    fetch_req = 1'b1; fetch_pc = 16'h3006;
    sample();
    check("lookup_after_write", {btb_hit, bbta[3], fetch_stall}, {1'b1, 16'h3100, 1'b0});

    // Starvation: one update under continuous fetch
    step();
    fetch_pc = 16'h0040;
    drive_upd(1'b1, 16'h4010, 16'h4200, 1'b1);
    sample();
    check("starve_upd_ready", upd_ready, 1'b1);
    step();
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      sample();
      check($sformatf("starve_wait_%0d", k), {fetch_stall, btb_ld_busy, btb_pc}, {2'b00, 16'h0040});
      step();
    end
    sample();
    check("starve_forced_write", {fetch_stall, btb_ld_busy, btb_pc}, {2'b11, 16'h4010});
    step();
    sample();
    check("starve_stall_released", {fetch_stall, btb_ld_busy}, 2'b00);

    // Fill the FIFO under continuous fetch
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive_upd(1'b1, 16'h5000 + 16'(2 * i), 16'h5100 + 16'(i), 1'b1);
      sample();
      check($sformatf("fill_ready_%0d", i), {upd_ready, btb_ld_busy}, 2'b10);
      step();
    end
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    sample();
    check("full_forced_write", {upd_ready, fetch_stall, btb_ld_busy, btb_pc, btb_bta_in},
          {3'b011, 16'h5000, 16'h5100});
    step();
    sample();
    check("full_ready_back", {upd_ready, fetch_stall, btb_ld_busy}, 3'b100);
    fetch_req = 1'b0;
    repeat (5) step();

    // Flush with two updates pending
    fetch_req = 1'b1; fetch_pc = 16'h0300;
    drive_upd(1'b1, 16'h6002, 16'h6100, 1'b1);
    step();
    drive_upd(1'b1, 16'h6004, 16'h6200, 1'b1);
    step();
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    flush_req = 1'b1;
    sample();
    check("flush_request_cycle", {upd_ready, flush_busy, btb_ld_valid, fetch_stall, btb_pc},
          {4'b0000, 16'h0300});
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample();
      check($sformatf("flush_walk_%0d", i),
            {flush_busy, upd_ready, fetch_stall, btb_ld_valid, btb_ld_tag, btb_ld_busy,
             btb_valid_in, btb_pc},
            {7'b1011000, 16'(2 * i)});
      step();
    end
    fetch_req = 1'b0; fetch_pc = 16'h5006;
    sample();
    check("flush_done", {flush_busy, upd_ready, btb_ld_valid, btb_hit}, 4'b0100);

    // Taken update then a not-taken update for the same PC
    step();
    drive_upd(1'b1, 16'h3006, 16'h3100, 1'b1);
    step();
    drive_upd(1'b1, 16'h3006, 16'h3200, 1'b0);
    fetch_pc = 16'h0100;
    sample();
    check("nt_ready", upd_ready, 1'b1);
    step();
    drive_upd(1'b0, 16'h0, 16'h0, 1'b0);
    sample();
`ifdef BTB_NT_INVALIDATE_EN
    check("nt_invalidate", {btb_ld_valid, btb_ld_tag, btb_ld_busy, btb_valid_in, btb_pc},
          {4'b1000, 16'h3006});
`else
    check("nt_dropped", {btb_ld_valid, btb_ld_tag, btb_ld_busy, btb_valid_in, btb_pc},
          {4'b0000, 16'h0100});
`endif
    step();
    fetch_req = 1'b1; fetch_pc = 16'h3006;
    sample();
    check("nt_lookup", btb_hit, NT_EN ? 1'b0 : 1'b1);

    // Reset in the middle of a flush walk
    step();
    fetch_pc = 16'h0200;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (5) step();
    sample();
    check("walk_index_5", {flush_busy, btb_pc}, {1'b1, 16'h000A});
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_flush",
          {fetch_stall, upd_ready, flush_busy, btb_ld_valid, btb_ld_tag, btb_ld_busy, btb_pc},
          {1'b0, 1'b1, 1'b0, 3'b000, 16'h0200});
    step();
    rst_n = 1'b1;
    sample();
    check("idle_after_reset", {flush_busy, upd_ready, fetch_stall, btb_ld_valid, btb_pc},
          {4'b0100, 16'h0200});
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_update_controller.md
# btb_update_controller

Sequences all writes into the branch target buffer and shares its single PC/index port between fetch-stage lookups and branch-resolution updates. Resolved branches from commit are buffered in a small FIFO and written into the BTB on cycles fetch leaves idle, or by force when the FIFO fills or an update starves. A full-invalidate walk recovers the BTB after context or program changes. The block sits between fetch, the commit/resolution logic and the BTB arrays.

## Interface
- QUEUE_DEPTH, 4, update FIFO entries (power of two, ≥2)
- INDEX_WIDTH, 4, BTB index bits; BTB indexed by pc[INDEX_WIDTH:1]
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before a forced write
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch wants a BTB lookup this cycle
- fetch_pc  in  16  fetch lookup PC
- fetch_stall  out  1  lookup not serviced this cycle; fetch must hold and retry
- upd_valid / upd_ready  in / out  1  update handshake; transfer when both high at a clock edge
- upd_pc, upd_target  in  16 each  resolved branch PC and target
- upd_taken  in  1  resolved direction
- flush_req  in  1  request a full BTB invalidate
- flush_busy  out  1  invalidate walk in progress
- btb_hit  in  1  BTB hit for the currently driven btb_pc (used only under the macro)
- btb_pc, btb_bta_in  out  16 each  BTB pc and bta_in
- btb_valid_in  out  1  BTB valid data
- btb_ld_valid, btb_ld_tag, btb_ld_busy  out  1 each  BTB load strobes

## Operation
- FSM states: IDLE, FLUSH. Reset → IDLE, FIFO empty, starve_cnt=0, flush_idx=0.
- Enqueue: in IDLE, upd_ready = !fifo_full && !flush_req. Taken updates are stored {pc,target,taken}. Not-taken updates are accepted and dropped (see Configuration).
- IDLE grant: write = !fifo_empty && (!fetch_req || fifo_full || starve_cnt ≥ STARVE_LIMIT) && !flush_req.
- Write cycle: pop head; btb_pc=head.pc, btb_bta_in=head.target, btb_valid_in=1, all three ld strobes =1; fetch_stall=fetch_req.
- Non-write cycle: btb_pc=fetch_pc, strobes 0, fetch_stall=0, btb_bta_in=0, btb_valid_in=0.
- starve_cnt: +1 (saturating at STARVE_LIMIT) each IDLE cycle with FIFO non-empty and no write; cleared on any write or when FIFO empty.
- Enqueue and pop in the same cycle are both honoured; count unchanged.
- flush_req high in IDLE: that cycle is a plain fetch cycle (no write, no enqueue). Next cycle → FLUSH; FIFO contents discarded; starve_cnt=0.
- FLUSH: btb_pc = flush_idx<<1 (zero elsewhere), btb_valid_in=0, btb_ld_valid=1, ld_tag/ld_busy=0, fetch_stall=fetch_req, upd_ready=0, flush_busy=1. flush_idx increments; after index 2^INDEX_WIDTH−1 → IDLE, flush_idx=0. flush_req ignored in FLUSH.
- Reset mid-walk or with pending updates: immediate return to reset state; BTB contents not guaranteed cleared.

## Timing
- Reset outputs: upd_ready=1, flush_busy=0, all strobes 0, fetch_stall=0, btb_pc=fetch_pc.
- fetch_stall, btb_pc, strobes are combinational from state, FIFO head, fetch_req/fetch_pc.
- Update accepted at edge N is writable at earliest in cycle N+1; written data visible to lookup the cycle after the write. No bypass from FIFO to lookup.
- Forced write happens at most STARVE_LIMIT+1 cycles after an entry reaches the FIFO head under continuous fetch_req.
- Flush: 2^INDEX_WIDTH cycles (16 by default) of flush_busy, plus the request cycle.

## Configuration
- BTB_NT_INVALIDATE_EN defined: not-taken updates are enqueued; at their write slot btb_pc=head.pc, and if btb_hit=1 only btb_ld_valid=1 with btb_valid_in=0 (entry invalidated); if btb_hit=0 no strobes. Either way the entry pops and the slot counts as a write (fetch_stall, starve_cnt clear).
- Undefined: not-taken updates handshake normally and are discarded; btb_hit ignored.

## Test plan
- Reset, fetch_req=0, one taken update pc=0x3006 target=0x3100 → written next cycle with btb_pc=0x3006, three strobes high, fetch_stall=0; lookup of 0x3006 two cycles later hits with bta 0x3100.
- fetch_req held high, one update queued → no write for 8 cycles, forced write on cycle 9 with fetch_stall=1 that cycle only.
- fetch_req high, 4 updates back-to-back → upd_ready drops when full, next cycle write forced, upd_ready returns 1.
- flush_req pulse with 2 updates queued → 16 cycles flush_busy=1, btb_pc=0x0000..0x001E step 2, ld_valid only; FIFO empty after; upd_ready=0 throughout.
- With BTB_NT_INVALIDATE_EN: not-taken update for resident 0x3006 with btb_hit=1 → ld_valid=1, valid_in=0, tag/busy strobes 0; without macro → no strobes ever.
- rst_n asserted at flush cycle 5 → all outputs at reset values immediately, state IDLE.
